// File: rtl/sprite_pkg.sv
// Shared types, constants and helpers for sprite_bouncer.
package sprite_pkg;

  localparam int unsigned MAX_SPR    = 8;
  localparam int unsigned SPR_IDX_W  = 3;
  localparam int unsigned POS_W      = 10;
  localparam int unsigned CAND_W     = POS_W + 2;
  localparam int unsigned RST_OFF_X  = 40;
  localparam int unsigned RST_OFF_Y  = 30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPD,
    ST_DONE
  } upd_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef struct packed {
    logic [POS_W-1:0] p;
    logic             dir;
  } axis_t;

  // Base colour of each sprite index.
  function automatic rgb_t base_colour(input int unsigned idx);
    case (idx)
      0:       return rgb_t'(12'hf00);
      1:       return rgb_t'(12'h0f0);
      2:       return rgb_t'(12'h00f);
      3:       return rgb_t'(12'h0ff);
      4:       return rgb_t'(12'hf0f);
      5:       return rgb_t'(12'hff0);
      6:       return rgb_t'(12'hfff);
      7:       return rgb_t'(12'h888);
      default: return rgb_t'(12'h000);
    endcase
  endfunction

  // Reset coordinate: lo + off*k, clamped so the sprite stays inside [lo, hi].
  function automatic logic [POS_W-1:0] rst_pos(input int unsigned k, input int unsigned off,
                                               input int unsigned lo, input int unsigned hi,
                                               input int unsigned size);
    int unsigned v;
    v = lo + off * k;
    if (v > hi - size + 1) v = hi - size + 1;
    return POS_W'(v);
  endfunction

  // One-axis move with reflection at the inclusive limits.
  function automatic axis_t bounce(input logic [POS_W-1:0] p, input logic dir,
                                   input int unsigned step, input int unsigned lo,
                                   input int unsigned hi, input int unsigned size);
    logic [CAND_W-1:0] cand;
    axis_t             res;
    cand = CAND_W'(p) + CAND_W'(step);
    if (dir) begin
      if (cand + CAND_W'(size) - CAND_W'(1) > CAND_W'(hi)) begin
        res.p   = POS_W'(hi - size + 1);
        res.dir = 1'b0;
      end else begin
        res.p   = cand[POS_W-1:0];
        res.dir = 1'b1;
      end
    end else begin
      // p - step < lo, rearranged so nothing underflows
      if (CAND_W'(p) < CAND_W'(lo) + CAND_W'(step)) begin
        res.p   = POS_W'(lo);
        res.dir = 1'b1;
      end else begin
        res.p   = POS_W'(CAND_W'(p) - CAND_W'(step));
        res.dir = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sprite_bouncer_if.sv
// Raster input / pixel output bundle of sprite_bouncer.
interface sprite_bouncer_if;
  logic [9:0] x;
  logic [8:0] y;
  logic       run;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       frame_done;

  modport master (output x, y, run, input r, g, b, frame_done);
  modport slave  (input x, y, run, output r, g, b, frame_done);
endinterface

// File: rtl/sprite_bouncer_sine_lut.sv
// sine_lut: 8-bit phase to 4-bit unsigned level (0 -> 8, 64 -> 15, 192 -> 0).
module sine_lut (
  input  logic [7:0] phase,
  output logic [3:0] level
);

  logic [5:0] idx;
  logic [2:0] mag;

  // Quarter-wave magnitude mirrored per quadrant; lower half sits one step below mid-scale.
  always_comb begin
    idx = phase[6] ? ~phase[5:0] : phase[5:0];
    case (idx[5:2])
      4'd0:                      mag = 3'd0;
      4'd1, 4'd2:                mag = 3'd1;
      4'd3:                      mag = 3'd2;
      4'd4:                      mag = 3'd3;
      4'd5, 4'd6:                mag = 3'd4;
      4'd7, 4'd8:                mag = 3'd5;
      4'd9, 4'd10, 4'd11:        mag = 3'd6;
      default:                   mag = 3'd7;
    endcase
    level = phase[7] ? {1'b0, 3'd7 - mag} : {1'b1, mag};
  end

endmodule

// File: rtl/sprite_bouncer.sv
// sprite_bouncer: N_SPR bouncing rectangles composited onto the raster, one
// sprite moved per cycle after each frame start. Optional macro
// SPRITE_PULSE_EN adds a per-update phase counter and sine brightness pulsing.
module sprite_bouncer
  import sprite_pkg::*;
#(
  parameter int unsigned N_SPR = 4,
  parameter int unsigned SPR_W = 100,
  parameter int unsigned SPR_H = 100,
  parameter int unsigned X_MIN = 50,
  parameter int unsigned X_MAX = 600,
  parameter int unsigned Y_MIN = 50,
  parameter int unsigned Y_MAX = 400,
  parameter int unsigned STEP  = 1
) (
  input logic            clk,
  input logic            rst_n,
  sprite_bouncer_if.slave bus
);

  localparam logic [SPR_IDX_W-1:0] K_LAST = SPR_IDX_W'(N_SPR - 1);

  upd_state_e           state_q, state_d;
  logic [SPR_IDX_W-1:0] k_q, k_d;
  logic                 frame_done_q, frame_done_d;
  logic                 prev_zero_q;
  logic                 at_origin_c, frame_start_c;
  logic [POS_W-1:0]     px_q [N_SPR];
  logic [POS_W-1:0]     px_d [N_SPR];
  logic [POS_W-1:0]     py_q [N_SPR];
  logic [POS_W-1:0]     py_d [N_SPR];
  logic                 dx_q [N_SPR];
  logic                 dx_d [N_SPR];
  logic                 dy_q [N_SPR];
  logic                 dy_d [N_SPR];
  rgb_t                 pix_q, pix_d;
  rgb_t                 colour_c [N_SPR];
  logic [N_SPR-1:0]     cover_c;

  assign at_origin_c   = (bus.x == '0) && (bus.y == '0);
  assign frame_start_c = at_origin_c && !prev_zero_q;

  // Update sequencer: walk k = 0..N_SPR-1, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_c && bus.run) begin
          state_d = ST_UPD;
          k_d     = '0;
        end
      end
      ST_UPD: begin
        if (k_q == K_LAST) state_d = ST_DONE;
        else               k_d     = k_q + SPR_IDX_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    frame_done_d = (state_d == ST_DONE);
  end

  // Move only the sprite currently selected by k.
  always_comb begin
    axis_t ax, ay;
    ax = '0;
    ay = '0;
    for (int k = 0; k < int'(N_SPR); k++) begin
      px_d[k] = px_q[k];
      py_d[k] = py_q[k];
      dx_d[k] = dx_q[k];
      dy_d[k] = dy_q[k];
      if (state_q == ST_UPD && k_q == SPR_IDX_W'(k)) begin
        ax      = bounce(px_q[k], dx_q[k], STEP, X_MIN, X_MAX, SPR_W);
        ay      = bounce(py_q[k], dy_q[k], STEP, Y_MIN, Y_MAX, SPR_H);
        px_d[k] = ax.p;
        dx_d[k] = ax.dir;
        py_d[k] = ay.p;
        dy_d[k] = ay.dir;
      end
    end
  end

`ifdef SPRITE_PULSE_EN
  logic [7:0] phase_q, phase_d;

  // Phase advances once per completed update.
  always_comb phase_d = (state_q == ST_DONE) ? phase_q + 8'd1 : phase_q;

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end
`endif

  // Per-sprite colour, optionally masked by its phase-shifted sine level.
  for (genvar k = 0; k < int'(N_SPR); k++) begin : g_colour
`ifdef SPRITE_PULSE_EN
    logic [3:0] level;
    sine_lut u_sine (
      .phase (phase_q + 8'(32 * k)),
      .level (level)
    );
    assign colour_c[k] = base_colour(k) & rgb_t'({level, level, level});
`else
    assign colour_c[k] = base_colour(k);
`endif
  end

  // Coverage test and lowest-index-wins compositing.
  always_comb begin
    pix_d = '0;
    for (int k = 0; k < int'(N_SPR); k++) begin
      cover_c[k] = (11'(bus.x) >= 11'(px_q[k])) &&
                   (11'(bus.x) <= 11'(px_q[k]) + 11'(SPR_W - 1)) &&
                   (11'(bus.y) >= 11'(py_q[k])) &&
                   (11'(bus.y) <= 11'(py_q[k]) + 11'(SPR_H - 1));
    end
    for (int k = int'(N_SPR) - 1; k >= 0; k--) begin
      if (cover_c[k]) pix_d = colour_c[k];
    end
  end

  // Control, pixel and sprite state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      frame_done_q <= 1'b0;
      prev_zero_q  <= 1'b1;
      pix_q        <= '0;
      for (int k = 0; k < int'(N_SPR); k++) begin
        px_q[k] <= rst_pos(k, RST_OFF_X, X_MIN, X_MAX, SPR_W);
        py_q[k] <= rst_pos(k, RST_OFF_Y, Y_MIN, Y_MAX, SPR_H);
        dx_q[k] <= ((k % 2) == 0);
        dy_q[k] <= (((k / 2) % 2) == 0);
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      frame_done_q <= frame_done_d;
      prev_zero_q  <= at_origin_c;
      pix_q        <= pix_d;
      for (int k = 0; k < int'(N_SPR); k++) begin
        px_q[k] <= px_d[k];
        py_q[k] <= py_d[k];
        dx_q[k] <= dx_d[k];
        dy_q[k] <= dy_d[k];
      end
    end
  end

  assign bus.r          = pix_q.r;
  assign bus.g          = pix_q.g;
  assign bus.b          = pix_q.b;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_bouncer.sv
// Bench for sprite_bouncer: two instances (STEP 1 and STEP 3) driven in lockstep,
// a behavioural position model and a pixel scoreboard.
`timescale 1ns/1ps
module tb_sprite_bouncer;

  localparam int N = 4, W = 100, H = 100;
  localparam int XMIN = 50, XMAX = 600, YMIN = 50, YMAX = 400;
  localparam int STEP_A = 1, STEP_B = 3;
  localparam logic [11:0] TB_BASE [8] = '{12'hf00, 12'h0f0, 12'h00f, 12'h0ff,
                                          12'hf0f, 12'hff0, 12'hfff, 12'h888};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_bouncer_if bus_a ();
  sprite_bouncer_if bus_b ();

  sprite_bouncer #(.N_SPR(N), .SPR_W(W), .SPR_H(H), .X_MIN(XMIN), .X_MAX(XMAX),
                   .Y_MIN(YMIN), .Y_MAX(YMAX), .STEP(STEP_A))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sprite_bouncer #(.N_SPR(N), .SPR_W(W), .SPR_H(H), .X_MIN(XMIN), .X_MAX(XMAX),
                   .Y_MIN(YMIN), .Y_MAX(YMAX), .STEP(STEP_B))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  int mpx [2][N];
  int mpy [2][N];
  bit mdx [2][N];
  bit mdy [2][N];
  int mphase = 0;
  bit cur_run = 1'b0;
  logic [11:0] q_a [$];
  logic [11:0] q_b [$];

  typedef struct {
    int          x;
    int          y;
    logic [11:0] base;
    int          idx;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y);
    bus_a.x = 10'(x); bus_b.x = 10'(x);
    bus_a.y = 9'(y);  bus_b.y = 9'(y);
  endtask

  task automatic set_run(input bit r);
    cur_run = r;
    bus_a.run = r; bus_b.run = r;
  endtask

`ifdef SPRITE_PULSE_EN
  function automatic int tb_sine(input int ph);
    int mags [16] = '{0, 1, 1, 2, 3, 4, 4, 5, 5, 6, 6, 6, 7, 7, 7, 7};
    int i;
    i = ((ph % 64) / 4);
    if (((ph / 64) % 2) == 1) i = 15 - i;
    return (ph < 128) ? 8 + mags[i] : 7 - mags[i];
  endfunction
`endif

  function automatic logic [11:0] mask(input int k);
`ifdef SPRITE_PULSE_EN
    logic [3:0] s;
    s = 4'(tb_sine((mphase + 32 * k) % 256));
    return {s, s, s};
`else
    return 12'hfff;
`endif
  endfunction

  function automatic logic [11:0] exp_pix(input int i, input int x, input int y);
    for (int k = 0; k < N; k++)
      if (x >= mpx[i][k] && x <= mpx[i][k] + W - 1 && y >= mpy[i][k] && y <= mpy[i][k] + H - 1)
        return TB_BASE[k] & mask(k);
    return 12'h000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < N; k++) begin
        mpx[i][k] = (XMIN + 40 * k > XMAX - W + 1) ? XMAX - W + 1 : XMIN + 40 * k;
        mpy[i][k] = (YMIN + 30 * k > YMAX - H + 1) ? YMAX - H + 1 : YMIN + 30 * k;
        mdx[i][k] = ((k % 2) == 0);
        mdy[i][k] = (((k / 2) % 2) == 0);
      end
    mphase = 0;
  endtask

  task automatic model_axis(inout int p, inout bit d, input int s, input int lo,
                            input int hi, input int size);
    if (d) begin
      if (p + s + size - 1 > hi) begin p = hi - size + 1; d = 1'b0; end
      else p = p + s;
    end else begin
      if (p - s < lo) begin p = lo; d = 1'b1; end
      else p = p - s;
    end
  endtask

  task automatic model_frame();
    int p; bit d; int s;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? STEP_A : STEP_B;
      for (int k = 0; k < N; k++) begin
        p = mpx[i][k]; d = mdx[i][k];
        model_axis(p, d, s, XMIN, XMAX, W);
        mpx[i][k] = p; mdx[i][k] = d;
        p = mpy[i][k]; d = mdy[i][k];
        model_axis(p, d, s, YMIN, YMAX, H);
        mpy[i][k] = p; mdy[i][k] = d;
      end
    end
    mphase = (mphase + 1) % 256;
  endtask

  // Drive one pixel, queue both expectations, compare after the output register.
  task automatic probe(input int x, input int y, input logic [11:0] ea, input logic [11:0] eb);
    set_pix(x, y);
    q_a.push_back(ea);
    q_b.push_back(eb);
    tick();
    check("pix_a", {bus_a.r, bus_a.g, bus_a.b}, q_a.pop_front());
    check("pix_b", {bus_b.r, bus_b.g, bus_b.b}, q_b.pop_front());
  endtask

  // Probe the corners and just-outside neighbours of every modelled sprite.
  task automatic probe_all();
    int xs [4];
    int ys [4];
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < N; k++) begin
        xs = '{mpx[i][k], mpx[i][k] - 1, mpx[i][k] + W - 1, mpx[i][k] + W};
        ys = '{mpy[i][k], mpy[i][k], mpy[i][k] + H - 1, mpy[i][k] + H - 1};
        for (int j = 0; j < 4; j++)
          probe(xs[j], ys[j], exp_pix(0, xs[j], ys[j]), exp_pix(1, xs[j], ys[j]));
      end
  endtask

  // One frame start; frame_done must pulse exactly N+1 cycles later when running.
  task automatic do_frame(input bit retrig);
    set_pix(5, 0);
    tick();
    set_pix(0, 0);
    for (int c = 1; c <= N + 3; c++) begin
      tick();
      check("frame_done_a", 32'(bus_a.frame_done), 32'(cur_run && c == N + 1));
      check("frame_done_b", 32'(bus_b.frame_done), 32'(cur_run && c == N + 1));
      if (retrig && c == 2) set_pix(0, 0);
      else                  set_pix(5, 0);
    end
    if (cur_run) model_frame();
  endtask

  initial begin
    int guard;
    vecs[0]  = '{60, 60, 12'hf00, 0};
    vecs[1]  = '{0, 0, 12'h000, 0};
    vecs[2]  = '{100, 100, 12'hf00, 0};
    vecs[3]  = '{150, 100, 12'h0f0, 1};
    vecs[4]  = '{200, 200, 12'h00f, 2};
    vecs[5]  = '{260, 230, 12'h0ff, 3};
    vecs[6]  = '{49, 60, 12'h000, 0};
    vecs[7]  = '{149, 149, 12'hf00, 0};
    vecs[8]  = '{150, 149, 12'h0f0, 1};
    vecs[9]  = '{270, 239, 12'h000, 0};
    vecs[10] = '{269, 239, 12'h0ff, 3};
    vecs[11] = '{599, 399, 12'h000, 0};

    set_pix(5, 0);
    set_run(1'b0);
    model_reset();
    repeat (3) tick();
    check("rst_rgb_a", {bus_a.r, bus_a.g, bus_a.b}, 12'h000);
    check("rst_rgb_b", {bus_b.r, bus_b.g, bus_b.b}, 12'h000);
    check("rst_fd_a", 32'(bus_a.frame_done), 0);
    rst_n = 1'b1;
    tick();

    // Reset-state pixel vectors, run held low throughout.
    for (int v = 0; v < 12; v++) begin
      probe(vecs[v].x, vecs[v].y, vecs[v].base & mask(vecs[v].idx),
            vecs[v].base & mask(vecs[v].idx));
      check("vec_fd", 32'(bus_a.frame_done), 0);
    end

    // Frame starts with run low: nothing moves, no frame_done.
    for (int f = 0; f < 5; f++) do_frame(1'b0);
    probe_all();

    // Ten running frames.
    set_run(1'b1);
    for (int f = 0; f < 10; f++) do_frame(1'b0);
    check("s0_px_after10", 32'(dut_a.px_q[0]), 60);
    check("s0_dx_after10", 32'(dut_a.dx_q[0]), 1);
    probe_all();

    // Second frame start during UPD is ignored.
    do_frame(1'b1);
    probe_all();

    // Right-edge bounce of sprite 2 in the STEP=3 instance.
    guard = 0;
    while (mpx[1][2] != 499 && guard < 300) begin
      do_frame(1'b0);
      guard++;
    end
    check("b_s2_px_499", 32'(dut_b.px_q[2]), 499);
    do_frame(1'b0);
    check("b_s2_px_501", 32'(dut_b.px_q[2]), 501);
    check("b_s2_dx_clr", 32'(dut_b.dx_q[2]), 0);
    do_frame(1'b0);
    check("b_s2_px_498", 32'(dut_b.px_q[2]), 498);
    probe_all();

    // Reset pulsed in the middle of an update.
    set_pix(5, 0);
    tick();
    set_pix(0, 0);
    tick();
    set_pix(5, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rgb", {bus_a.r, bus_a.g, bus_a.b}, 12'h000);
    check("midrst_fd", 32'(bus_a.frame_done), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < N + 2; c++) begin
      tick();
      check("post_rst_fd", 32'(bus_a.frame_done), 0);
    end
    probe_all();
    do_frame(1'b0);
    probe_all();

`ifdef SPRITE_PULSE_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int f = 0; f < 64; f++) do_frame(1'b0);
    check("phase_64", 32'(dut_a.phase_q), 64);
    probe(114, 114, 12'hf00, exp_pix(1, 114, 114));
    for (int f = 0; f < 128; f++) do_frame(1'b0);
    check("phase_192", 32'(dut_a.phase_q), 192);
    probe(242, 242, 12'h000, exp_pix(1, 242, 242));
    probe_all();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_bouncer.md
SPRITE_BOUNCER -- requirements
Module: sprite_bouncer

Interface
REQ-001 Parameter N_SPR, default 4, number of sprites (1..8).
REQ-002 Parameter SPR_W, default 100, sprite width in pixels.
REQ-003 Parameter SPR_H, default 100, sprite height in pixels.
REQ-004 Parameter X_MIN / X_MAX, default 50 / 600, horizontal bounce limits (inclusive).
REQ-005 Parameter Y_MIN / Y_MAX, default 50 / 400, vertical bounce limits (inclusive).
REQ-006 Parameter STEP, default 1, pixels moved per frame per axis (1..15).
REQ-007 clk  input  1  pixel clock; the block has one clock, and reset is asynchronous and active-low.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 x  input  10  current pixel column.
REQ-010 y  input  9  current pixel row.
REQ-011 run  input  1  1 = sprites move each frame; 0 = positions and directions hold.
REQ-012 r, g, b  output  4 each  registered pixel colour.
REQ-013 frame_done  output  1  one-cycle pulse when the per-frame update completes.

Function
REQ-014 The block SHALL detect frame start as the cycle where (x,y) becomes (0,0) having been different on the previous cycle; only one update per frame.
REQ-015 Update FSM SHALL have states IDLE, UPD, DONE: IDLE->UPD on frame start with run=1; UPD processes sprite index k=0..N_SPR-1, one per cycle; UPD->DONE after k=N_SPR-1; DONE->IDLE next cycle with frame_done=1 for exactly that cycle.
REQ-016 Frame start with run=0 SHALL leave the FSM in IDLE and assert no frame_done.
REQ-017 Frame start arriving while not in IDLE SHALL be ignored.
REQ-018 Each sprite SHALL hold top-left (px[9:0], py[9:0]) and direction bits dx, dy (1 = increasing).
REQ-019 Per axis update: candidate = p ± STEP; if dx=1 and candidate+SPR_W-1 > X_MAX, p SHALL become X_MAX-SPR_W+1 and dx SHALL clear; if dx=0 and candidate < X_MIN (computed without underflow), p SHALL become X_MIN and dx SHALL set; otherwise p = candidate. Y identical with SPR_H, Y_MIN, Y_MAX.
REQ-020 Sprite k covers pixels px<=x<=px+SPR_W-1 and py<=y<=py+SPR_H-1 (inclusive, 11-bit comparison, no wrap).
REQ-021 Overlap SHALL resolve by priority: lowest covering index wins; no covering sprite gives colour 12'h000.
REQ-022 r,g,b SHALL be registered with latency of exactly 1 clk from x,y.
REQ-023 Compositing SHALL use positions as currently registered; an update during the visible area is allowed and takes effect on the next cycle.

Reset
REQ-024 On rst_n=0 all outputs SHALL be 0, FSM in IDLE, phase counter 0.
REQ-025 Reset sprite k: px = X_MIN + 40*k, py = Y_MIN + 30*k (clamped to legal range), dx = k[0] inverted, dy = k[1] inverted.
REQ-026 Reset assertion mid-UPD SHALL abort the update; after release the first frame start begins a full update from k=0.

Configuration
REQ-027 Macro SPRITE_PULSE_EN defined: an 8-bit phase counter SHALL increment per completed update, and each sprite colour channel SHALL equal base channel AND the 4-bit sine value at phase+32*k.
REQ-028 Macro SPRITE_PULSE_EN undefined: no phase counter or sine logic; colours equal base table values.

Structure
REQ-029 Shared package sprite_pkg SHALL hold the base colour table (index0 12'hf00, 1 12'h0f0, 2 12'h00f, 3 12'h0ff, 4 12'hf0f, 5 12'hff0, 6 12'hfff, 7 12'h888), the FSM state enumeration and the reset-offset constants 40 and 30.
REQ-030 Sub-module sine_lut (8-bit phase in, 4-bit unsigned out, combinational, 0 -> 8, 64 -> 15, 192 -> 0) SHALL be instantiated once per sprite when SPRITE_PULSE_EN is defined.

Verification
REQ-031 Reset, defaults, pixel (60,60) -> after 1 clk r,g,b = f,0,0; pixel (0,0) -> 0,0,0.
REQ-032 run=1, 10 frame starts, sprite 0 from px=50 dx=1 -> px=60, frame_done pulsed 10 times, each pulse N_SPR+1 cycles after frame start.
REQ-033 Sprite at px=499 dx=1, SPR_W=100, STEP=3 -> px=501, dx=0; next frame px=498.
REQ-034 Sprites 0 and 1 overlapping at pixel -> output sprite 0 colour 12'hf00.
REQ-035 run=0 across 5 frame starts -> positions unchanged, no frame_done; rst_n pulsed mid-UPD -> reset positions restored.
REQ-036 SPRITE_PULSE_EN defined, phase 64 after 64 updates -> sprite 0 colour f,0,0; phase 192 -> 0,0,0.
